// File: rtl/io_in_pkg.sv
// Shared types and constants for the board input conditioner.
package io_in_pkg;

    // Debounce state of one push button (1 = pressed after polarity fix-up).
    typedef enum logic [1:0] {
        RELEASED,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } btn_state_e;

    // Flops in every clock-domain-crossing synchroniser.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: polarity fix-up, synchroniser, debounce FSM
// with saturating stability counter, registered level and edge pulses.
module btn_debounce
    import io_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_raw,
    output logic o_btn,
    output logic o_btn_press,
    output logic o_btn_release
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                   raw_norm;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    btn_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             btn_d, press_d, release_d;

    // Internally 1 always means pressed, so reset value 0 reads as released.
    assign raw_norm = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;
    assign s        = sync_q[SYNC_STAGES-1];

    // Synchroniser, FSM state, counter and registered outputs.
    // NOTE: every clocked assignment is non-blocking so all flops sample the
    // pre-edge values together; blocking here would collapse the sync chain.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q        <= '0;
            state         <= RELEASED;
            cnt           <= '0;
            o_btn         <= 1'b0;
            o_btn_press   <= 1'b0;
            o_btn_release <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], raw_norm};
            state         <= state_d;
            cnt           <= cnt_d;
            o_btn         <= btn_d;
            o_btn_press   <= press_d;
            o_btn_release <= release_d;
        end
    end

    // Next state: a change is accepted only if s is still stable on the
    // edge where the counter has already reached DEBOUNCE_CYCLES.
    // NOTE: defaults first so every path assigns every output; otherwise a
    // latch is inferred for the unassigned branches.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            RELEASED: begin
                if (s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the transition, registered above.
    always_comb begin
        btn_d     = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
        press_d   = (state == WAIT_PRESS)   && (state_d == PRESSED);
        release_d = (state == WAIT_RELEASE) && (state_d == RELEASED);
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Board input front end: synchronised slide switches and debounced push
// buttons with press/release pulses, all on the core clock.
module io_input_conditioner
    import io_in_pkg::*;
#(
    parameter int N_SW            = 32,
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_SW-1:0]  i_sw_raw,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_SW-1:0]  o_sw,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release
);

    logic [SYNC_STAGES-1:0][N_SW-1:0] sw_sync;

    // Switch synchroniser chain, no debounce: switches are slow levels.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sw_sync <= '0;
        end else begin
            sw_sync <= {sw_sync[SYNC_STAGES-2:0], i_sw_raw};
        end
    end

    assign o_sw = sw_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_btn (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_btn_raw     (i_btn_raw[i]),
            .o_btn         (o_btn[i]),
            .o_btn_press   (o_btn_press[i]),
            .o_btn_release (o_btn_release[i])
        );
    end

endmodule
